// File: rtl/operand_stage_if.sv
// Decode-to-operand-stage handshake: the decoded instruction bundle and the
// stall back-pressure that tells decode to hold its instruction.
interface operand_stage_if #(
   parameter int XLEN      = 32,
   parameter int REG_DEPTH = 32,
   parameter int CTRL_W    = 8
);
   localparam int RW = $clog2(REG_DEPTH);

   logic              in_valid;
   logic [RW-1:0]     in_rs1;
   logic [RW-1:0]     in_rs2;
   logic [RW-1:0]     in_rd;
   logic              in_use_rs1;
   logic              in_use_rs2;
   logic              in_is_load;
   logic [XLEN-1:0]   in_imm;
   logic [XLEN-1:0]   in_pc;
   logic [CTRL_W-1:0] in_ctrl;
   logic              stall_out;

   // Decode side drives the instruction and obeys the stall.
   modport master (
      output in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2,
             in_is_load, in_imm, in_pc, in_ctrl,
      input  stall_out
   );

   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2,
             in_is_load, in_imm, in_pc, in_ctrl,
      output stall_out
   );
endinterface

// File: rtl/operand_stage.sv
// ID/EX operand stage: register-file read, same-cycle writeback bypass, load-use bubble,
// flush/hold. Optional bubble counter enabled by defining OPERAND_STAGE_STALL_CNT_EN.
module operand_stage #(
   parameter int XLEN      = 32,
   parameter int REG_DEPTH = 32,
   parameter int CTRL_W    = 8,
   localparam int RW       = $clog2(REG_DEPTH)
) (
   input  logic              clock,
   input  logic              reset_n,
   operand_stage_if.slave    dec,
   output logic [RW-1:0]     rf_addr1,
   output logic [RW-1:0]     rf_addr2,
   input  logic [XLEN-1:0]   rf_data1,
   input  logic [XLEN-1:0]   rf_data2,
   input  logic              wb_wren,
   input  logic [RW-1:0]     wb_reg,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush,
   input  logic              ex_hold,
   output logic              ex_valid,
   output logic [RW-1:0]     ex_rs1,
   output logic [RW-1:0]     ex_rs2,
   output logic [RW-1:0]     ex_rd,
   output logic              ex_is_load,
   output logic [XLEN-1:0]   ex_op1,
   output logic [XLEN-1:0]   ex_op2,
   output logic [XLEN-1:0]   ex_imm,
   output logic [XLEN-1:0]   ex_pc,
`ifdef OPERAND_STAGE_STALL_CNT_EN
   output logic [31:0]       stall_cnt,
`endif
   output logic [CTRL_W-1:0] ex_ctrl
);

   logic [XLEN-1:0] op1_n;
   logic [XLEN-1:0] op2_n;
   logic            hz;
   logic            wb_live;

   assign rf_addr1 = dec.in_rs1;
   assign rf_addr2 = dec.in_rs2;

   // The register file commits on the same edge we capture, so its read port
   // still shows the old value; substitute the in-flight write (never for x0).
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      op1_n   = rf_data1;
      op2_n   = rf_data2;
      wb_live = wb_wren && (wb_reg != '0);
      if (wb_live && (wb_reg == dec.in_rs1)) op1_n = wb_data;
      if (wb_live && (wb_reg == dec.in_rs2)) op2_n = wb_data;
   end

   // Load data is not available until after EX, so a dependent instruction waits one cycle.
   always_comb begin
      hz = 1'b0;
      if (dec.in_valid && ex_valid && ex_is_load && (ex_rd != '0))
         hz = (dec.in_use_rs1 && (dec.in_rs1 == ex_rd)) ||
              (dec.in_use_rs2 && (dec.in_rs2 == ex_rd));
   end

   assign dec.stall_out = !flush && (ex_hold || hz);

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   // NOTE: every pipeline register is reset; there is no memory array here to exempt.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ex_valid   <= 1'b0;
         ex_rs1     <= '0;
         ex_rs2     <= '0;
         ex_rd      <= '0;
         ex_is_load <= 1'b0;
         ex_op1     <= '0;
         ex_op2     <= '0;
         ex_imm     <= '0;
         ex_pc      <= '0;
         ex_ctrl    <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (ex_hold) begin
         ex_valid <= ex_valid;
      end else if (hz) begin
         ex_valid <= 1'b0;
      end else begin
         ex_valid   <= dec.in_valid;
         ex_rs1     <= dec.in_rs1;
         ex_rs2     <= dec.in_rs2;
         ex_rd      <= dec.in_rd;
         ex_is_load <= dec.in_is_load;
         ex_op1     <= op1_n;
         ex_op2     <= op2_n;
         ex_imm     <= dec.in_imm;
         ex_pc      <= dec.in_pc;
         ex_ctrl    <= dec.in_ctrl;
      end
   end

`ifdef OPERAND_STAGE_STALL_CNT_EN
   // Counts inserted bubbles only; free-running wrap is intended.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         stall_cnt <= '0;
      else if (hz && !flush && !ex_hold)
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule

// File: doc/operand_stage.md
Name: operand_stage

Overview:
- ID/EX operand stage of the RV32 pipeline, between decode and execute.
- Drives the register-file read addresses combinationally and captures the returned read data.
- Bypasses a same-cycle writeback to a source register, detects load-use hazards (one bubble), and registers the decoded instruction into EX with flush/hold support.

Parameters:
XLEN, 32, datapath/operand width
REG_DEPTH, 32, architectural register count; index width RW = $clog2(REG_DEPTH)
CTRL_W, 8, width of opaque decoded control bundle passed to EX

Ports:
clock  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
in_valid  in  1  decode presents an instruction
in_rs1, in_rs2, in_rd  in  RW each  source/destination indices
in_use_rs1, in_use_rs2  in  1 each  instruction actually reads rs1/rs2
in_is_load  in  1  instruction is a load
in_imm  in  XLEN  decoded immediate
in_pc  in  XLEN  instruction PC
in_ctrl  in  CTRL_W  control bundle
rf_addr1, rf_addr2  out  RW each  register-file read addresses
rf_data1, rf_data2  in  XLEN each  register-file read data (combinational)
wb_wren, wb_reg, wb_data  in  1/RW/XLEN  writeback port, same values driven to register file
flush  in  1  EX resolved taken branch/jump; kill this stage
ex_hold  in  1  EX cannot accept; freeze outputs
stall_out  out  1  decode must hold its instruction this cycle
ex_valid  out  1  registered: EX instruction valid
ex_rs1, ex_rs2, ex_rd  out  RW each  registered indices
ex_is_load  out  1  registered
ex_op1, ex_op2, ex_imm, ex_pc  out  XLEN each  registered
ex_ctrl  out  CTRL_W  registered

Behaviour:
- Reset: every registered output is 0; ex_valid=0. Reset mid-operation drops any in-flight instruction.
- Combinational outputs: rf_addr1=in_rs1, rf_addr2=in_rs2.
- Writeback bypass (the register file writes on the clock edge, so the same-cycle write is invisible to its read):
  - op1_n = wb_data if wb_wren && wb_reg!=0 && wb_reg==in_rs1, else rf_data1.
  - op2_n is formed the same way from in_rs2 and rf_data2.
  - A write to x0 is never bypassed.
- Load-use hazard, hz = all of:
  - in_valid && ex_valid && ex_is_load && ex_rd!=0, and
  - (in_use_rs1 && in_rs1==ex_rd) || (in_use_rs2 && in_rs2==ex_rd).
- stall_out = !flush && (ex_hold || hz). Combinational.
- Next-state priority per clock edge:
  1. flush: ex_valid<=0, other fields may hold; the in_valid instruction is discarded (decode is flushed by the same signal).
  2. ex_hold: all ex_* hold their values.
  3. hz: ex_valid<=0 (bubble), other fields hold; decode retries next cycle, when the load has left EX.
  4. Otherwise: ex_valid<=in_valid; capture rs1/rs2/rd/is_load/imm/pc/ctrl and op1_n/op2_n. Fields may also be captured when in_valid=0.
- Latency: one cycle from decode to EX. At most one bubble per load-use pair.
- Forwarding from the EX/MEM and MEM/WB pipeline registers belongs to the EX stage, not this block. This block only covers the same-cycle register-file write.
- Held instruction under ex_hold: operands are not re-read or re-bypassed.
- All registers use async active-low reset_n on negedge, and update on posedge clock.

Optional Feature:
OPERAND_STAGE_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt [31:0], reset to 0.
  - Increments by 1 on every clock edge where hz=1, flush=0 and ex_hold=0, i.e. each inserted bubble.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset → capture: reset_n low mid-stream → all ex_* 0. Release reset, in_valid=1, rs1=5, rs2=6, rf_data1=0x11, rf_data2=0x22, pc=0x100 → next cycle ex_valid=1, ex_op1=0x11, ex_op2=0x22, ex_pc=0x100.
- WB bypass: rs1=7 with wb_wren=1, wb_reg=7, wb_data=0xDEAD, rf_data1=0x0 → ex_op1=0xDEAD. Same with wb_reg=0 and rs1=0 → ex_op1=rf_data1 (0).
- Load-use: ex holds load to rd=3; decode in_rs2=3, in_use_rs2=1 → stall_out=1, next ex_valid=0. Following cycle the instruction is captured; stall_cnt=1 when the macro is defined. The same pattern with in_use_rs2=0, or ex_rd=0 → no stall.
- Flush priority: flush=1 together with hz=1 and ex_hold=1 → stall_out=0, next ex_valid=0, stall_cnt unchanged.
- ex_hold: ex_valid=1, ex_op1=0x55; ex_hold=1 for 3 cycles with changing inputs → stall_out=1, all ex_* unchanged. Deassert → next decode instruction is captured.
